// File: rtl/maxpool_row_scheduler.sv
// -----------------------------------------------------------------------------
// maxpool_row_scheduler
//
// Walks one pooling layer pass row by row. For every channel c (outer loop) and
// every output row r (inner loop) it reads the up to three input rows 2r-1,
// 2r, 2r+1 of that channel from row memory and ORs them together, which is the
// vertical part of a 3x3 / stride 2 / pad 1 spike max-pool (row -1 is padding
// and is never read). The OR'd row goes to an external pool unit for the
// horizontal part. The pool unit's result is presented on a valid/ready output
// port tagged with its channel and row. Only one row read is outstanding at a
// time and nothing is fetched while a result waits to be accepted.
//
// Ports
//   s_clk, s_rst          clock; asynchronous active-high reset
//   code_valid            strobe: latch conv_in_ch / conv_img_size
//   conv_in_ch            channel count C (0 = empty pass)
//   conv_img_size         input row/column size S, even, 4..IMG_WIDTH
//   i_start               start a pass (accepted only when idle)
//   o_busy                high in every state except IDLE
//   o_done                one-cycle pulse at the end of a pass
//   o_rd_req, o_rd_addr   one-cycle row read request, address c*S + row
//   i_rd_valid, i_rd_data row read return
//   o_row_data_valid      one-cycle strobe of the OR'd row to the pool unit
//   o_row_data            OR'd row
//   i_calculating_flag    pool unit busy; holds the next row back
//   i_pooling_valid       pool unit result strobe
//   i_pooling_data        pool unit result
//   o_out_valid, i_out_ready  result handshake
//   o_out_data, o_out_ch, o_out_row  result and its channel / output row
// -----------------------------------------------------------------------------
module maxpool_row_scheduler #(
  parameter int IMG_WIDTH  = 16,
  parameter int TIME_STEPS = 2
) (
  input  logic                            s_clk,
  input  logic                            s_rst,

  input  logic                            code_valid,
  input  logic [15:0]                     conv_in_ch,
  input  logic [15:0]                     conv_img_size,

  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,

  output logic                            o_rd_req,
  output logic [15:0]                     o_rd_addr,
  input  logic                            i_rd_valid,
  input  logic [IMG_WIDTH*TIME_STEPS-1:0] i_rd_data,

  output logic                            o_row_data_valid,
  output logic [IMG_WIDTH*TIME_STEPS-1:0] o_row_data,
  input  logic                            i_calculating_flag,
  input  logic                            i_pooling_valid,
  input  logic [IMG_WIDTH*TIME_STEPS-1:0] i_pooling_data,

  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [IMG_WIDTH*TIME_STEPS-1:0] o_out_data,
  output logic [15:0]                     o_out_ch,
  output logic [15:0]                     o_out_row
);

  localparam int DATA_W = IMG_WIDTH * TIME_STEPS;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    ISSUE,
    WAIT_POOL,
    OUT,
    DONE
  } state_t;

  state_t              state;

  // Configuration as last written, and the copy frozen for the running pass.
  logic [15:0]         cfg_ch;
  logic [15:0]         cfg_size;
  logic [15:0]         pass_ch;
  logic [15:0]         pass_size;

  // Loop position: channel, output row, first-address-of-channel (c*S kept as
  // a running sum so no multiplier is needed) and which of the three input
  // rows of the window is being fetched (0 -> 2r-1, 1 -> 2r, 2 -> 2r+1).
  logic [15:0]         ch_cnt;
  logic [15:0]         row_cnt;
  logic [15:0]         row_base;
  logic [1:0]          fetch_k;

  logic [DATA_W-1:0]   acc;

  logic [15:0]         row_addr;
  logic [15:0]         last_row;
  logic [15:0]         last_ch;

  // All address arithmetic is 16-bit and wraps modulo 2^16.
  assign row_addr = row_base + (row_cnt << 1) - 16'd1 + {14'd0, fetch_k};
  assign last_row = (pass_size >> 1) - 16'd1;
  assign last_ch  = pass_ch - 16'd1;

  // NOTE: every register here, including the row accumulator and the output
  // data registers, is cleared by reset so a reset in mid-pass leaves no
  // stale row or result that a late handshake could expose.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state            <= IDLE;
      cfg_ch           <= '0;
      cfg_size         <= '0;
      pass_ch          <= '0;
      pass_size        <= '0;
      ch_cnt           <= '0;
      row_cnt          <= '0;
      row_base         <= '0;
      fetch_k          <= '0;
      acc              <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_rd_req         <= 1'b0;
      o_rd_addr        <= '0;
      o_row_data_valid <= 1'b0;
      o_row_data       <= '0;
      o_out_valid      <= 1'b0;
      o_out_data       <= '0;
      o_out_ch         <= '0;
      o_out_row        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the single-cycle strobes
      // get a default of 0 here and are raised only by the state that owns
      // them, so each is exactly one cycle wide.
      o_rd_req         <= 1'b0;
      o_row_data_valid <= 1'b0;
      o_done           <= 1'b0;

      if (code_valid) begin
        cfg_ch   <= conv_in_ch;
        cfg_size <= conv_img_size;
      end

      unique case (state)
        IDLE: begin
          if (i_start) begin
            pass_ch   <= cfg_ch;
            pass_size <= cfg_size;
            ch_cnt    <= '0;
            row_cnt   <= '0;
            row_base  <= '0;
            fetch_k   <= 2'd1;  // row 0 has no row above it
            acc       <= '0;
            o_busy    <= 1'b1;
            state     <= (cfg_ch == 16'd0) ? DONE : FETCH;
          end
        end

        FETCH: begin
          o_rd_req  <= 1'b1;
          o_rd_addr <= row_addr;
          state     <= WAIT_RD;
        end

        WAIT_RD: begin
          if (i_rd_valid) begin
            acc <= acc | i_rd_data;
            if (fetch_k == 2'd2) begin
              state <= ISSUE;
            end else begin
              fetch_k <= fetch_k + 2'd1;
              state   <= FETCH;
            end
          end
        end

        ISSUE: begin
          if (!i_calculating_flag) begin
            o_row_data_valid <= 1'b1;
            o_row_data       <= acc;
            state            <= WAIT_POOL;
          end
        end

        WAIT_POOL: begin
          if (i_pooling_valid) begin
            o_out_data  <= i_pooling_data;
            o_out_ch    <= ch_cnt;
            o_out_row   <= row_cnt;
            o_out_valid <= 1'b1;
            state       <= OUT;
          end
        end

        OUT: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            acc         <= '0;
            if (row_cnt == last_row) begin
              if (ch_cnt == last_ch) begin
                state <= DONE;
              end else begin
                ch_cnt   <= ch_cnt + 16'd1;
                row_cnt  <= '0;
                row_base <= row_base + pass_size;
                fetch_k  <= 2'd1;
                state    <= FETCH;
              end
            end else begin
              row_cnt <= row_cnt + 16'd1;
              fetch_k <= 2'd0;
              state   <= FETCH;
            end
          end
        end

        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_maxpool_row_scheduler
//
// Bench for maxpool_row_scheduler. A row memory and a stand-in pool unit
// respond to the DUT with fixed latencies. The expected read addresses, OR'd
// rows and tagged results of a pass are listed up front from the pooling rule
// (output row r = OR of input rows 2r-1..2r+1 that exist) and one monitor
// process compares every DUT strobe and transfer against that list. Directed
// scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_maxpool_row_scheduler;

  localparam int IW = 16;
  localparam int TS = 2;
  localparam int DW = IW * TS;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [15:0]   ch;
    logic [15:0]   row;
  } out_t;

  logic          s_clk = 1'b0;
  logic          s_rst;
  logic          code_valid;
  logic [15:0]   conv_in_ch;
  logic [15:0]   conv_img_size;
  logic          i_start;
  logic          o_busy;
  logic          o_done;
  logic          o_rd_req;
  logic [15:0]   o_rd_addr;
  logic          i_rd_valid;
  logic [DW-1:0] i_rd_data;
  logic          o_row_data_valid;
  logic [DW-1:0] o_row_data;
  logic          i_calculating_flag;
  logic          i_pooling_valid;
  logic [DW-1:0] i_pooling_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_out_data;
  logic [15:0]   o_out_ch;
  logic [15:0]   o_out_row;

  maxpool_row_scheduler #(.IMG_WIDTH(IW), .TIME_STEPS(TS)) dut (
    .s_clk              (s_clk),
    .s_rst              (s_rst),
    .code_valid         (code_valid),
    .conv_in_ch         (conv_in_ch),
    .conv_img_size      (conv_img_size),
    .i_start            (i_start),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_rd_req           (o_rd_req),
    .o_rd_addr          (o_rd_addr),
    .i_rd_valid         (i_rd_valid),
    .i_rd_data          (i_rd_data),
    .o_row_data_valid   (o_row_data_valid),
    .o_row_data         (o_row_data),
    .i_calculating_flag (i_calculating_flag),
    .i_pooling_valid    (i_pooling_valid),
    .i_pooling_data     (i_pooling_data),
    .o_out_valid        (o_out_valid),
    .i_out_ready        (i_out_ready),
    .o_out_data         (o_out_data),
    .o_out_ch           (o_out_ch),
    .o_out_row          (o_out_row)
  );

  always #5 s_clk = ~s_clk;

  // Row memory contents and the stand-in pool unit's function.
  logic [DW-1:0] mem [256];

  function automatic logic [DW-1:0] pool_fn(input logic [DW-1:0] x);
    return x | (x << 1);
  endfunction

  // Expected behaviour, written by the main process only.
  logic [15:0]   exp_addr [$];
  logic [DW-1:0] exp_row  [$];
  out_t          exp_out  [$];

  // Observations, written by the monitor only.
  logic [15:0]   addr_log [$];
  out_t          out_log  [$];
  int            ai, ri, oi;
  int            cyc, rd_req_cnt, row_pulse_cnt, xfer_cnt, done_cnt;
  int            last_xfer_cyc, done_cyc;

  int            n_checks = 0;
  int            n_pass   = 0;

  // Control knobs for the responders, written by the main process only.
  bit            pool_hold = 1'b0;
  int            stray_cnt = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: list reads, OR'd rows and tagged results of a pass of C x S.
  task automatic build_expected(input int c_n, input int s_n);
    logic [15:0]   a;
    logic [DW-1:0] acc;
    out_t          o;
    for (int c = 0; c < c_n; c++) begin
      for (int r = 0; r < s_n / 2; r++) begin
        acc = '0;
        for (int row = 2 * r - 1; row <= 2 * r + 1; row++) begin
          if (row >= 0) begin
            a = 16'(c * s_n + row);
            exp_addr.push_back(a);
            acc = acc | mem[a[7:0]];
          end
        end
        exp_row.push_back(acc);
        o.data = pool_fn(acc);
        o.ch   = 16'(c);
        o.row  = 16'(r);
        exp_out.push_back(o);
      end
    end
  endtask

  // Row memory: answers each request two cycles later.
  logic [15:0] rq_addr [$];
  int          rq_due  [$];
  initial begin
    int          lc;
    logic [15:0] a;
    lc = 0;
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    forever begin
      @(negedge s_clk);
      lc++;
      i_rd_valid = 1'b0;
      if (s_rst) begin
        rq_addr.delete();
        rq_due.delete();
      end else begin
        if (rq_due.size() > 0 && rq_due[0] <= lc) begin
          a = rq_addr.pop_front();
          void'(rq_due.pop_front());
          i_rd_valid = 1'b1;
          i_rd_data  = mem[a[7:0]];
        end
        if (o_rd_req) begin
          rq_addr.push_back(o_rd_addr);
          rq_due.push_back(lc + 2);
        end
      end
    end
  end

  // Pool unit stand-in: returns pool_fn(row) three cycles later, or a stray
  // all-ones pulse on request.
  logic [DW-1:0] pq_data [$];
  int            pq_due  [$];
  initial begin
    int lc;
    int stray_seen;
    lc = 0;
    stray_seen = 0;
    i_pooling_valid = 1'b0;
    i_pooling_data  = '0;
    forever begin
      @(negedge s_clk);
      lc++;
      i_pooling_valid = 1'b0;
      if (s_rst) begin
        pq_data.delete();
        pq_due.delete();
      end else begin
        if (stray_seen != stray_cnt) begin
          stray_seen      = stray_cnt;
          i_pooling_valid = 1'b1;
          i_pooling_data  = '1;
        end else if (pq_due.size() > 0 && pq_due[0] <= lc) begin
          i_pooling_valid = 1'b1;
          i_pooling_data  = pq_data.pop_front();
          void'(pq_due.pop_front());
        end
        if (o_row_data_valid && !pool_hold) begin
          pq_data.push_back(pool_fn(o_row_data));
          pq_due.push_back(lc + 3);
        end
      end
    end
  end

  // Monitor: compares every strobe and transfer against the model.
  initial begin
    out_t cur;
    out_t held;
    bit   stalled;
    stalled = 1'b0;
    held = '0;
    cyc = 0; rd_req_cnt = 0; row_pulse_cnt = 0; xfer_cnt = 0; done_cnt = 0;
    last_xfer_cyc = 0; done_cyc = 0; ai = 0; ri = 0; oi = 0;
    forever begin
      @(negedge s_clk);
      #1;
      cyc++;
      if (s_rst) begin
        ai = exp_addr.size();
        ri = exp_row.size();
        oi = exp_out.size();
        stalled = 1'b0;
      end else begin
        if (o_rd_req) begin
          rd_req_cnt++;
          addr_log.push_back(o_rd_addr);
          if (ai < exp_addr.size()) begin
            check_eq("rd_addr", o_rd_addr, exp_addr[ai]);
            ai++;
          end else fail("rd_req_unexpected", o_rd_addr, 0);
        end
        if (o_row_data_valid) begin
          row_pulse_cnt++;
          if (ri < exp_row.size()) begin
            check_eq("row_data", o_row_data, exp_row[ri]);
            ri++;
          end else fail("row_valid_unexpected", o_row_data, 0);
        end
        cur.data = o_out_data;
        cur.ch   = o_out_ch;
        cur.row  = o_out_row;
        if (o_out_valid) begin
          if (stalled) check_eq("out_hold_stable", cur, held);
          if (i_out_ready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            out_log.push_back(cur);
            if (oi < exp_out.size()) begin
              check_eq("out_xfer", cur, exp_out[oi]);
              oi++;
            end else fail("out_unexpected", cur, 0);
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held    = cur;
          end
        end else begin
          stalled = 1'b0;
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic configure(input int c_n, input int s_n);
    @(negedge s_clk);
    code_valid    = 1'b1;
    conv_in_ch    = 16'(c_n);
    conv_img_size = 16'(s_n);
    @(negedge s_clk);
    code_valid    = 1'b0;
  endtask

  task automatic start_pass();
    @(negedge s_clk);
    i_start = 1'b1;
    @(negedge s_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      @(negedge s_clk);
      n++;
    end
    if (!o_done) fail(name, n, budget);
  endtask

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int abase, obase, dbase, rbase, rq, n;
    bit ok;
    logic [15:0]   a_addr [11];
    logic [DW-1:0] a_data [4];
    logic [15:0]   b_ch   [6];
    logic [15:0]   b_row  [6];
    a_addr = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd4, 16'd5, 16'd5, 16'd6, 16'd7};
    a_data = '{32'h0000_0007, 32'h0000_001E, 32'h0000_0078, 32'h0000_01E0};
    b_ch   = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};
    b_row  = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};

    for (int i = 0; i < 256; i++) mem[i] = 32'(1) << (i % 32);

    s_rst              = 1'b1;
    code_valid         = 1'b0;
    conv_in_ch         = '0;
    conv_img_size      = '0;
    i_start            = 1'b0;
    i_calculating_flag = 1'b0;
    i_out_ready        = 1'b1;

    // Reset state.
    #12;
    check_eq("rst_busy",      o_busy, 0);
    check_eq("rst_done",      o_done, 0);
    check_eq("rst_rd_req",    {o_rd_req, o_rd_addr}, 0);
    check_eq("rst_row_valid", {o_row_data_valid, o_row_data}, 0);
    check_eq("rst_out",       {o_out_valid, o_out_data, o_out_ch, o_out_row}, 0);
    @(negedge s_clk);
    s_rst = 1'b0;

    // Idle after reset until configured and started.
    repeat (5) @(negedge s_clk);
    check_eq("idle_busy",  o_busy, 0);
    check_eq("idle_reads", rd_req_cnt, 0);

    // A: S=8, C=1.
    configure(1, 8);
    build_expected(1, 8);
    abase = addr_log.size();
    obase = out_log.size();
    start_pass();
    check_eq("A_busy", o_busy, 1);
    wait_done("A_done_timeout", 400);
    repeat (3) @(negedge s_clk);
    check_eq("A_busy_after", o_busy, 0);
    check_eq("A_n_reads", addr_log.size() - abase, 11);
    if (addr_log.size() - abase >= 11)
      for (int i = 0; i < 11; i++) check_eq($sformatf("A_addr%0d", i), addr_log[abase + i], a_addr[i]);
    check_eq("A_n_out", out_log.size() - obase, 4);
    if (out_log.size() - obase >= 4)
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("A_data%0d", i), out_log[obase + i].data, a_data[i]);
        check_eq($sformatf("A_row%0d", i),  out_log[obase + i].row, 16'(i));
      end

    // B: S=4, C=3, with an i_start pulse mid-pass that must be ignored.
    configure(3, 4);
    build_expected(3, 4);
    abase = addr_log.size();
    obase = out_log.size();
    dbase = done_cnt;
    start_pass();
    repeat (15) @(negedge s_clk);
    start_pass();
    wait_done("B_done_timeout", 600);
    repeat (8) @(negedge s_clk);
    check_eq("B_n_out", out_log.size() - obase, 6);
    if (out_log.size() - obase >= 6)
      for (int i = 0; i < 6; i++) begin
        check_eq($sformatf("B_ch%0d", i),  out_log[obase + i].ch,  b_ch[i]);
        check_eq($sformatf("B_row%0d", i), out_log[obase + i].row, b_row[i]);
      end
    if (addr_log.size() > abase) check_eq("B_last_addr", addr_log[addr_log.size() - 1], 16'd11);
    else fail("B_no_reads", addr_log.size(), abase + 1);
    check_eq("B_done_pulses", done_cnt - dbase, 1);
    check_eq("B_done_after_xfer", done_cyc - last_xfer_cyc, 2);

    // C: consumer stalls 10 cycles on the first result.
    configure(1, 4);
    build_expected(1, 4);
    obase = out_log.size();
    i_out_ready = 1'b0;
    start_pass();
    n = 0;
    while (!o_out_valid && n < 200) begin @(negedge s_clk); n++; end
    if (!o_out_valid) fail("C_valid_timeout", n, 200);
    rq = rd_req_cnt;
    ok = 1'b1;
    repeat (10) begin
      @(negedge s_clk);
      if (!o_out_valid) ok = 1'b0;
    end
    check_eq("C_valid_held", ok, 1);
    check_eq("C_no_reads_in_stall", rd_req_cnt, rq);
    i_out_ready = 1'b1;
    wait_done("C_done_timeout", 200);
    repeat (3) @(negedge s_clk);
    check_eq("C_n_out", out_log.size() - obase, 2);

    // D: pool unit busy for 5 cycles while a row waits to be issued.
    configure(1, 4);
    build_expected(1, 4);
    obase = out_log.size();
    rbase = row_pulse_cnt;
    rq = rd_req_cnt;
    i_calculating_flag = 1'b1;
    start_pass();
    n = 0;
    while (rd_req_cnt - rq < 2 && n < 100) begin @(negedge s_clk); n++; end
    repeat (6) @(negedge s_clk);
    ok = 1'b1;
    repeat (5) begin
      @(negedge s_clk);
      if (o_row_data_valid) ok = 1'b0;
    end
    check_eq("D_no_issue_while_busy", ok, 1);
    check_eq("D_rows_before_release", row_pulse_cnt - rbase, 0);
    i_calculating_flag = 1'b0;
    wait_done("D_done_timeout", 200);
    repeat (3) @(negedge s_clk);
    check_eq("D_row_pulses", row_pulse_cnt - rbase, 2);
    check_eq("D_n_out", out_log.size() - obase, 2);

    // E: reset while waiting on the pool unit, then a stray pool strobe.
    configure(1, 4);
    build_expected(1, 4);
    pool_hold = 1'b1;
    start_pass();
    n = 0;
    while (!o_row_data_valid && n < 100) begin @(negedge s_clk); n++; end
    if (!o_row_data_valid) fail("E_issue_timeout", n, 100);
    repeat (2) @(negedge s_clk);
    s_rst = 1'b1;
    #1;
    check_eq("E_rst_busy",  o_busy, 0);
    check_eq("E_rst_valid", o_out_valid, 0);
    repeat (2) @(negedge s_clk);
    s_rst = 1'b0;
    pool_hold = 1'b0;
    rq = rd_req_cnt;
    obase = out_log.size();
    stray_cnt++;
    ok = 1'b1;
    repeat (6) begin
      @(negedge s_clk);
      if (o_out_valid || o_busy) ok = 1'b0;
    end
    check_eq("E_stray_ignored", ok, 1);
    check_eq("E_no_reads_after_rst", rd_req_cnt, rq);
    configure(1, 4);
    build_expected(1, 4);
    start_pass();
    wait_done("E_done_timeout", 200);
    repeat (3) @(negedge s_clk);
    check_eq("E_n_out", out_log.size() - obase, 2);

    // F: zero channels.
    configure(0, 8);
    rq = rd_req_cnt;
    obase = out_log.size();
    @(negedge s_clk);
    i_start = 1'b1;
    @(negedge s_clk);
    i_start = 1'b0;
    check_eq("F_done_not_yet", o_done, 0);
    check_eq("F_busy", o_busy, 1);
    @(negedge s_clk);
    check_eq("F_done", o_done, 1);
    @(negedge s_clk);
    check_eq("F_done_one_cycle", o_done, 0);
    repeat (3) @(negedge s_clk);
    check_eq("F_no_reads", rd_req_cnt, rq);
    check_eq("F_no_out", out_log.size(), obase);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
